// File: rtl/hsmooth_bst_pkg.sv
// Shared definitions for the hsmooth_bst horizontal smoothing stage:
// FSM state encodings, default frame geometry and the RGB pixel bundle.
package hsmooth_bst_pkg;

  localparam int DEF_WIDTH  = 128;
  localparam int DEF_HEIGHT = 128;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STREAM = 3'd3,
    ST_FLUSH  = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } rgb_t;

endpackage

// File: rtl/hsmooth_bst_tap3.sv
// Per-channel 3-tap [1 2 1]/4 kernel with rounding. The first/last flags
// replicate the centre pixel at the row edges, so neighbouring rows never mix.
module hsmooth_bst_tap3 (
  input  logic [7:0] left,
  input  logic [7:0] center,
  input  logic [7:0] right,
  input  logic       first,
  input  logic       last,
  output logic [7:0] result
);

  logic [7:0] left_sel;
  logic [7:0] right_sel;
  logic [9:0] sum;

  // Edge-replicate selects, then (l + 2c + r + 2) >> 2; the 10-bit sum peaks at 1022.
  always_comb begin
    left_sel  = first ? center : left;
    right_sel = last  ? center : right;
    sum       = {2'b00, left_sel} + {1'b0, center, 1'b0} + {2'b00, right_sel} + 10'd2;
    result    = sum[9:2];
  end

endmodule

// File: rtl/hsmooth_bst.sv
// hsmooth_bst: pulls one frame from an upstream frame buffer, applies a
// horizontal 3-tap smoothing filter per channel and streams the result to a
// downstream frame buffer. Optional feature macro: HSMOOTH_BYPASS_EN adds a
// bypass input that passes pixels through with identical timing.
module hsmooth_bst
  import hsmooth_bst_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int CNT_W  = 14
) (
  input  logic       clk,
  input  logic       reset,
  output logic       src_req,
  input  logic       src_ack,
  input  logic [7:0] pixel_a_in,
  input  logic [7:0] pixel_b_in,
  input  logic [7:0] pixel_c_in,
`ifdef HSMOOTH_BYPASS_EN
  input  logic       bypass,
`endif
  input  logic       dst_req,
  output logic       dst_ack,
  output logic [7:0] pixel_a_out,
  output logic [7:0] pixel_b_out,
  output logic [7:0] pixel_c_out,
  output logic       busy,
  output logic [2:0] state
);

  localparam int PIXEL_NUM = WIDTH * HEIGHT;
  localparam int COL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIXEL_NUM - 2);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

  state_t           st;
  logic [CNT_W-1:0] cnt;      // index of the most recently captured input pixel
  logic [COL_W-1:0] out_col;  // column of the next output pixel
  rgb_t             prev_px;  // in[x-1]
  rgb_t             cur_px;   // in[x]
  rgb_t             in_px;    // in[x+1], straight from the port
  rgb_t             filt_px;
  rgb_t             out_px;
  logic             use_bypass;
  logic             left_edge;
  logic             right_edge;

  assign in_px      = '{a: pixel_a_in, b: pixel_b_in, c: pixel_c_in};
  assign left_edge  = (out_col == '0);
  assign right_edge = (out_col == LAST_COL);

`ifdef HSMOOTH_BYPASS_EN
  logic bypass_q;
  assign use_bypass = bypass_q;
`else
  assign use_bypass = 1'b0;
`endif

  hsmooth_bst_tap3 u_tap_a (
    .left(prev_px.a), .center(cur_px.a), .right(in_px.a),
    .first(left_edge), .last(right_edge), .result(filt_px.a)
  );
  hsmooth_bst_tap3 u_tap_b (
    .left(prev_px.b), .center(cur_px.b), .right(in_px.b),
    .first(left_edge), .last(right_edge), .result(filt_px.b)
  );
  hsmooth_bst_tap3 u_tap_c (
    .left(prev_px.c), .center(cur_px.c), .right(in_px.c),
    .first(left_edge), .last(right_edge), .result(filt_px.c)
  );

  // Handshake FSM, pixel window, column tracking and registered outputs.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the window registers are reset too so a discarded partial frame leaves nothing behind.
      st      <= ST_IDLE;
      src_req <= 1'b0;
      dst_ack <= 1'b0;
      cnt     <= '0;
      out_col <= '0;
      prev_px <= '0;
      cur_px  <= '0;
      out_px  <= '0;
`ifdef HSMOOTH_BYPASS_EN
      bypass_q <= 1'b0;
`endif
    end else begin
      src_req <= 1'b0;
      dst_ack <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (dst_req) begin
            st      <= ST_REQ;
            src_req <= 1'b1;
          end
        end
        ST_REQ: st <= ST_WAIT;
        ST_WAIT: begin
          if (src_ack) begin
            cur_px  <= in_px;
            cnt     <= '0;
            out_col <= '0;
`ifdef HSMOOTH_BYPASS_EN
            bypass_q <= bypass;
`endif
            st <= (PIXEL_NUM == 1) ? ST_FLUSH : ST_STREAM;
          end
        end
        ST_STREAM: begin
          out_px  <= use_bypass ? cur_px : filt_px;
          dst_ack <= 1'b1;
          out_col <= right_edge ? '0 : out_col + 1'b1;
          prev_px <= cur_px;
          cur_px  <= in_px;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_CNT) st <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // The last pixel always sits in the last column, so right_edge is set here.
          out_px  <= use_bypass ? cur_px : filt_px;
          dst_ack <= 1'b1;
          out_col <= '0;
          st      <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (st != ST_IDLE);
  assign state       = st;
  assign pixel_a_out = out_px.a;
  assign pixel_b_out = out_px.b;
  assign pixel_c_out = out_px.c;

endmodule

// File: tb/tb_hsmooth_bst.sv
// Self-checking bench for hsmooth_bst: full-frame runs compared against a
// per-pixel reference of the smoothing rule, a table of hand-derived spot
// values, and hand-written handshake / reset sequences.
module tb_hsmooth_bst;
  import hsmooth_bst_pkg::*;

  localparam int W = 128;
  localparam int H = 128;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic       src_req;
  logic       src_ack;
  logic [7:0] pixel_a_in, pixel_b_in, pixel_c_in;
  logic       dst_req;
  logic       dst_ack;
  logic [7:0] pixel_a_out, pixel_b_out, pixel_c_out;
  logic       busy;
  logic [2:0] state;
`ifdef HSMOOTH_BYPASS_EN
  logic       bypass;
`endif

  always #5 clk = ~clk;

  hsmooth_bst #(.WIDTH(W), .HEIGHT(H), .CNT_W(14)) dut (
    .clk(clk), .reset(reset),
    .src_req(src_req), .src_ack(src_ack),
    .pixel_a_in(pixel_a_in), .pixel_b_in(pixel_b_in), .pixel_c_in(pixel_c_in),
`ifdef HSMOOTH_BYPASS_EN
    .bypass(bypass),
`endif
    .dst_req(dst_req), .dst_ack(dst_ack),
    .pixel_a_out(pixel_a_out), .pixel_b_out(pixel_b_out), .pixel_c_out(pixel_c_out),
    .busy(busy), .state(state)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] fin_a [N];
  logic [7:0] fin_b [N];
  logic [7:0] fin_c [N];
  logic [7:0] got_a [$];
  logic [7:0] got_b [$];
  logic [7:0] got_c [$];

  int req_width, ack_rise_k, ack_count, ack_runs;

  typedef struct {
    string name;
    int    ch;
    int    row;
    int    col;
    int    exp;
  } spot_t;
  spot_t spots [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int in_px(input int ch, input int idx);
    case (ch)
      0:       return int'(fin_a[idx]);
      1:       return int'(fin_b[idx]);
      default: return int'(fin_c[idx]);
    endcase
  endfunction

  function automatic int got_px(input int ch, input int idx);
    if (idx >= got_a.size()) return -1;
    case (ch)
      0:       return int'(got_a[idx]);
      1:       return int'(got_b[idx]);
      default: return int'(got_c[idx]);
    endcase
  endfunction

  // Reference: rows are independent, edge pixels replicate themselves.
  function automatic int expect_px(input int ch, input int idx, input bit byp);
    int x, c, l, r;
    x = idx % W;
    c = in_px(ch, idx);
    l = (x == 0)     ? c : in_px(ch, idx - 1);
    r = (x == W - 1) ? c : in_px(ch, idx + 1);
    return byp ? c : (l + 2 * c + r + 2) / 4;
  endfunction

  task automatic drive_px(input int idx);
    pixel_a_in = fin_a[idx];
    pixel_b_in = fin_b[idx];
    pixel_c_in = fin_c[idx];
  endtask

  // One handshake + burst. abort_at > 0 returns right after that sample.
  task automatic run_frame(input int delay, input int abort_at, input bit drop_ctl, input bit byp);
    bit seen_req, prev_ack;
    got_a.delete(); got_b.delete(); got_c.delete();
    req_width = 0; ack_rise_k = -1; ack_count = 0; ack_runs = 0;
    prev_ack = 1'b0; seen_req = 1'b0;
    dst_req = 1'b1;
    for (int i = 0; i < 100 && !seen_req; i++) begin
      tick();
      if (src_req) seen_req = 1'b1;
    end
    check("src_req_seen", 32'(seen_req), 1);
    if (!seen_req) begin
      dst_req = 1'b0;
      return;
    end
    req_width = 1;
    for (int i = 0; i < delay; i++) begin
      tick();
      if (src_req) req_width++;
    end
    check("src_req_width", req_width, 1);
`ifdef HSMOOTH_BYPASS_EN
    bypass = byp;
`endif
    src_ack = 1'b1;
    drive_px(0);
    for (int k = 1; k <= N + 3; k++) begin
      tick();
      if (dst_ack) begin
        got_a.push_back(pixel_a_out);
        got_b.push_back(pixel_b_out);
        got_c.push_back(pixel_c_out);
        ack_count++;
        if (!prev_ack) begin
          ack_runs++;
          if (ack_rise_k < 0) ack_rise_k = k;
        end
      end
      prev_ack = dst_ack;
      if (k == abort_at) return;
      if (k < N) drive_px(k);
      if (k == N) dst_req = 1'b0;
      if (drop_ctl && k == 1000) begin
        src_ack = 1'b0;
        dst_req = 1'b0;
      end
    end
    src_ack = 1'b0;
    dst_req = 1'b0;
`ifdef HSMOOTH_BYPASS_EN
    bypass = 1'b0;
`endif
  endtask

  task automatic check_frame(input string tag, input bit byp);
    int mism, first_bad;
    check({tag, "_ack_rise"}, ack_rise_k, 2);
    check({tag, "_ack_len"}, ack_count, N);
    check({tag, "_ack_runs"}, ack_runs, 1);
    mism = 0; first_bad = -1;
    for (int i = 0; i < N; i++)
      for (int ch = 0; ch < 3; ch++)
        if (got_px(ch, i) != expect_px(ch, i, byp)) begin
          mism++;
          if (first_bad < 0) first_bad = i;
        end
    check($sformatf("%s_pixels(first_bad=%0d)", tag, first_bad), mism, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_src_req"}, 32'(src_req), 0);
    check({tag, "_dst_ack"}, 32'(dst_ack), 0);
    check({tag, "_outs"}, {8'd0, pixel_a_out, pixel_b_out, pixel_c_out}, 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_state"}, 32'(state), 32'(ST_IDLE));
  endtask

  initial begin
    int hits;
    spots[0] = '{"ramp_x0",      0, 3, 0,   1};
    spots[1] = '{"ramp_x64",     0, 3, 64,  128};
    spots[2] = '{"ramp_x127",    0, 3, 127, 254};
    spots[3] = '{"imp_x9",       1, 5, 9,   64};
    spots[4] = '{"imp_x10",      1, 5, 10,  128};
    spots[5] = '{"imp_x11",      1, 5, 11,  64};
    spots[6] = '{"imp_x127",     1, 5, 127, 191};
    spots[7] = '{"imp_row6_x0",  1, 6, 0,   0};

    reset = 1'b1; src_ack = 1'b0; dst_req = 1'b0;
    pixel_a_in = '0; pixel_b_in = '0; pixel_c_in = '0;
`ifdef HSMOOTH_BYPASS_EN
    bypass = 1'b0;
`endif
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;

    // dst_req low: no request may go out, and src_ack in IDLE is ignored.
    hits = 0;
    src_ack = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (src_req) hits++;
    end
    src_ack = 1'b0;
    check("idle_no_src_req", hits, 0);
    check("idle_state", 32'(state), 32'(ST_IDLE));

    // Constant frame, src_ack seven cycles after the request.
    for (int i = 0; i < N; i++) begin fin_a[i] = 100; fin_b[i] = 100; fin_c[i] = 100; end
    run_frame(7, 0, 1'b0, 1'b0);
    check_frame("const", 1'b0);
    check("const_out_px0", got_px(0, 0), 100);

    // Ramp on a, impulses on b, random on c; control inputs drop mid-burst.
    for (int i = 0; i < N; i++) begin
      fin_a[i] = 8'(2 * (i % W));
      fin_b[i] = 8'd0;
      fin_c[i] = 8'($urandom_range(0, 255));
    end
    fin_b[5 * W + 10]  = 8'd255;
    fin_b[5 * W + 127] = 8'd255;
    run_frame(3, 0, 1'b1, 1'b0);
    check_frame("mixed", 1'b0);
    for (int i = 0; i < 8; i++)
      check(spots[i].name, got_px(spots[i].ch, spots[i].row * W + spots[i].col), spots[i].exp);

    // Reset right after input pixel 5000 is captured.
    for (int i = 0; i < N; i++) begin
      fin_a[i] = 8'($urandom_range(0, 255));
      fin_b[i] = 8'($urandom_range(0, 255));
      fin_c[i] = 8'($urandom_range(0, 255));
    end
    run_frame(2, 5001, 1'b0, 1'b0);
    check("abort_ack_before", 32'(dst_ack), 1);
    reset = 1'b1; src_ack = 1'b0; dst_req = 1'b0;
    tick();
    check_idle_outputs("midreset");
    reset = 1'b0;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dst_ack || src_req) hits++;
    end
    check("post_reset_quiet", hits, 0);

    // A fresh constant frame must behave exactly like the first one.
    for (int i = 0; i < N; i++) begin fin_a[i] = 100; fin_b[i] = 100; fin_c[i] = 100; end
    run_frame(7, 0, 1'b0, 1'b0);
    check_frame("after_reset", 1'b0);

`ifdef HSMOOTH_BYPASS_EN
    for (int i = 0; i < N; i++) begin
      fin_a[i] = 8'($urandom_range(0, 255));
      fin_b[i] = 8'($urandom_range(0, 255));
      fin_c[i] = 8'($urandom_range(0, 255));
    end
    run_frame(4, 0, 1'b0, 1'b1);
    check_frame("bypass", 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
